// File: rtl/dbg_bus_arbiter.sv
// dbg_bus_arbiter: shares the system memory bus between the core master and the debug module.
// Latency: data path is combinational (0 cycles); debug takeover from an idle core takes 2 cycles, and release takes 2 cycles.
// Backpressure: the core is stalled through core_hold_o; each master holds its req until its ack.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   core_* (req/we/addr/wdata in, rdata/ack out), core_hold_o   core master side
//   dbg_*  (req/we/addr/wdata in, rdata/ack out), halt_req_i    debug module side
//   bus_*  (req/we/addr/wdata out, rdata/ack in)                interconnect side
//   dbg_grant_o              high while the debug module owns the bus
//   bus_err_o                one-cycle pulse on a timeout abort
//
// Optional feature: define DBG_ARB_TIMEOUT_EN to build the ack timeout counter
// (TIMEOUT_CYCLES / TO_W). If it is not defined, the arbiter waits for bus_ack_i forever.
module dbg_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_ack_o,
  output logic        core_hold_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_ack_o,
  input  logic        halt_req_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        dbg_grant_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    ST_CORE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DBG     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_own_core;
  logic        w_own_dbg;
  logic        w_timeout;
  logic        w_ack;
  logic [31:0] w_rdata;

  // The core keeps the bus through DRAIN so that its in-flight access can finish.
  assign w_own_core = (r_state == ST_CORE) || (r_state == ST_DRAIN);
  assign w_own_dbg  = (r_state == ST_DBG);

  // A timeout abort looks like a normal completion to the owner, but it returns zero data.
  assign w_ack   = bus_ack_i | w_timeout;
  assign w_rdata = w_timeout ? 32'h0 : bus_rdata_i;

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    if (w_own_core) begin
      bus_req_o   = core_req_i;
      bus_we_o    = core_we_i;
      bus_addr_o  = core_addr_i;
      bus_wdata_o = core_wdata_i;
    end else if (w_own_dbg) begin
      bus_req_o   = dbg_req_i;
      bus_we_o    = dbg_we_i;
      bus_addr_o  = dbg_addr_i;
      bus_wdata_o = dbg_wdata_i;
    end
  end

  assign core_ack_o   = w_own_core & w_ack;
  assign core_rdata_o = w_own_core ? w_rdata : 32'h0;
  assign dbg_ack_o    = w_own_dbg & w_ack;
  assign dbg_rdata_o  = w_own_dbg ? w_rdata : 32'h0;
  assign core_hold_o  = (r_state != ST_CORE);
  assign dbg_grant_o  = w_own_dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CORE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CORE: begin
        if (dbg_req_i || halt_req_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Hand over once the core is idle or its access completes in this cycle.
        if (!core_req_i || w_ack) w_state_nxt = ST_DBG;
      end
      ST_DBG: begin
        // A debug access that completes in this cycle counts as no longer pending.
        // This lets release start right after the last ack.
        if (!halt_req_i && (!dbg_req_i || w_ack)) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_state_nxt = ST_CORE;
      end
    endcase
  end

`ifdef DBG_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_owner_chg;

  // Ownership changes only when the bus enters or leaves DBG; CORE and DRAIN share one owner.
  assign w_owner_chg = (w_state_nxt == ST_DBG) != w_own_dbg;
  // A real ack in the limit cycle wins, so that no error is reported.
  assign w_timeout   = bus_req_o & ~bus_ack_i & (r_to_cnt == TO_LAST);
  assign bus_err_o   = w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (bus_req_o && !w_ack && !w_owner_chg) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYCLES != TO_W);
  assign w_timeout    = 1'b0;
  assign bus_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// tb_dbg_bus_arbiter: directed stimulus with a phase-level reference model and literal checkpoints.
// Latency: not applicable (testbench).
// Backpressure: a bus responder acks each request after a programmable number of wait cycles, or never.
module tb_dbg_bus_arbiter;

  localparam int TMO   = 16;
  localparam int LIMIT = 200;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  localparam int P_CORE = 0;
  localparam int P_DRAIN = 1;
  localparam int P_DBG = 2;
  localparam int P_REL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic        core_ack_o, core_hold_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ack_o, halt_req_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i, dbg_grant_o, bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  int          rsp_lat;
  logic [31:0] rsp_data;
  int          rcnt;

  int  m_phase;
  int  m_wait;
  int  m_nxt;
  bit  m_live = 1'b0;
  logic e_own_core, e_own_dbg, e_breq, e_to, e_ack;
  logic [31:0] e_rd;

  bit mon_hold = 1'b0;
  bit hold_low_seen = 1'b0;

  always #5 clk = ~clk;

  dbg_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_ack_o(core_ack_o),
    .core_hold_o(core_hold_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .halt_req_i(halt_req_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .dbg_grant_o(dbg_grant_o), .bus_err_o(bus_err_o)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Interconnect responder: acks once a request has waited rsp_lat cycles. A negative rsp_lat means never.
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    rcnt        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0; rcnt = 0;
      end else if (!bus_req_o) begin
        bus_ack_i = 1'b0; bus_rdata_i = JUNK; rcnt = 0;
      end else if (rsp_lat >= 0 && rcnt == rsp_lat) begin
        bus_ack_i = 1'b1; bus_rdata_i = rsp_data; rcnt = 0;
      end else begin
        bus_ack_i = 1'b0; bus_rdata_i = JUNK; rcnt++;
      end
    end
  end

  // Reference model: it tracks the ownership phase and the cycles a request has gone unanswered.
  always_comb begin
    e_own_core = (m_phase == P_CORE) || (m_phase == P_DRAIN);
    e_own_dbg  = (m_phase == P_DBG);
    e_breq     = e_own_core ? core_req_i : (e_own_dbg ? dbg_req_i : 1'b0);
    e_to       = 1'b0;
`ifdef DBG_ARB_TIMEOUT_EN
    e_to = e_breq && !bus_ack_i && (m_wait == TMO - 1);
`endif
    e_ack = bus_ack_i || e_to;
    e_rd  = e_to ? 32'h0 : bus_rdata_i;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_CORE;
      m_wait  <= 0;
      m_live  <= 1'b1;
    end else begin
      m_nxt = m_phase;
      if (m_phase == P_CORE && (dbg_req_i || halt_req_i)) m_nxt = P_DRAIN;
      if (m_phase == P_DRAIN && (!core_req_i || e_ack)) m_nxt = P_DBG;
      if (m_phase == P_DBG && !halt_req_i && (!dbg_req_i || e_ack)) m_nxt = P_REL;
      if (m_phase == P_REL) m_nxt = P_CORE;
      if (e_breq && !e_ack && ((m_nxt == P_DBG) == (m_phase == P_DBG))) m_wait <= m_wait + 1;
      else m_wait <= 0;
      m_phase <= m_nxt;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk1("core_ack", core_ack_o, e_own_core && e_ack);
      chk32("core_rdata", core_rdata_o, e_own_core ? e_rd : 32'h0);
      chk1("dbg_ack", dbg_ack_o, e_own_dbg && e_ack);
      chk32("dbg_rdata", dbg_rdata_o, e_own_dbg ? e_rd : 32'h0);
      chk1("core_hold", core_hold_o, m_phase != P_CORE);
      chk1("dbg_grant", dbg_grant_o, e_own_dbg);
      chk1("bus_req", bus_req_o, e_breq);
      chk1("bus_err", bus_err_o, e_to);
      if (m_phase != P_REL) begin
        chk1("bus_we", bus_we_o, e_own_core ? core_we_i : dbg_we_i);
        chk32("bus_addr", bus_addr_o, e_own_core ? core_addr_i : dbg_addr_i);
        chk32("bus_wdata", bus_wdata_o, e_own_core ? core_wdata_i : dbg_wdata_i);
      end
    end
    if (mon_hold && !core_hold_o) hold_low_seen = 1'b1;
  end

  task automatic dbg_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output int waited);
    bit got;
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = wd;
    got = 1'b0; rd = 32'h0;
    for (waited = 0; waited < LIMIT; waited++) begin
      @(negedge clk);
      if (dbg_ack_o) begin
        got = 1'b1; rd = dbg_rdata_o;
        break;
      end
      tick();
    end
    chk1("dbg_access_ack_seen", got, 1'b1);
    tick();
    dbg_req_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    int          acks;
    bit          got;
    int          k;

    rst = 1'b1;
    core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    halt_req_i = 0; rsp_lat = 0; rsp_data = 0;

    // During reset, the arbiter is in core pass-through, with no hold, no grant, and no acks.
    tick();
    core_req_i = 1'b1; core_addr_i = 32'h0000_ABCD;
    @(negedge clk);
    chk1("rst_hold", core_hold_o, 1'b0);
    chk1("rst_grant", dbg_grant_o, 1'b0);
    chk1("rst_bus_req", bus_req_o, 1'b1);
    chk32("rst_bus_addr", bus_addr_o, 32'h0000_ABCD);
    chk1("rst_core_ack", core_ack_o, 1'b0);
    chk32("rst_dbg_rdata", dbg_rdata_o, 32'h0);
    chk1("rst_err", bus_err_o, 1'b0);
    tick();
    core_req_i = 1'b0; core_addr_i = 32'h0; rst = 1'b0;
    tick();

    // Idle core, debug read: grant after 2 cycles, and ack 2 cycles after the bus request.
    rsp_lat = 2; rsp_data = 32'hCAFE_F00D;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h1000_0000;
    @(negedge clk); chk1("t1_grant_n0", dbg_grant_o, 1'b0);
    tick(); @(negedge clk); chk1("t1_hold_n1", core_hold_o, 1'b1); chk1("t1_grant_n1", dbg_grant_o, 1'b0);
    tick(); @(negedge clk); chk1("t1_grant_n2", dbg_grant_o, 1'b1); chk32("t1_bus_addr", bus_addr_o, 32'h1000_0000);
    tick(); @(negedge clk); chk1("t1_ack_n3", dbg_ack_o, 1'b0);
    tick(); @(negedge clk); chk1("t1_ack_n4", dbg_ack_o, 1'b1); chk32("t1_rdata", dbg_rdata_o, 32'hCAFE_F00D);
    tick(); dbg_req_i = 1'b0;
    @(negedge clk); chk1("t1_rel_grant", dbg_grant_o, 1'b0); chk1("t1_rel_hold", core_hold_o, 1'b1);
    chk1("t1_rel_bus_req", bus_req_o, 1'b0);
    tick(); @(negedge clk); chk1("t1_core_hold", core_hold_o, 1'b0);
    tick();

    // A core read is in flight with its ack 5 cycles late. Debug arrives one cycle after it.
    rsp_lat = 5; rsp_data = 32'h1111_2222;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_2000;
    tick();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h0000_3000; dbg_wdata_i = 32'h5555_AAAA;
    tick(); tick(); tick();
    @(negedge clk); chk1("t2_core_ack_early", core_ack_o, 1'b0);
    tick(); @(negedge clk);
    chk1("t2_core_ack", core_ack_o, 1'b1); chk32("t2_core_rdata", core_rdata_o, 32'h1111_2222);
    chk1("t2_grant_drain", dbg_grant_o, 1'b0);
    tick(); core_req_i = 1'b0; rsp_lat = 1; rsp_data = 32'h0BAD_0BAD;
    @(negedge clk);
    chk1("t2_grant", dbg_grant_o, 1'b1); chk32("t2_bus_addr", bus_addr_o, 32'h0000_3000);
    chk32("t2_bus_wdata", bus_wdata_o, 32'h5555_AAAA); chk32("t2_core_rdata_dbg", core_rdata_o, 32'h0);
    tick(); @(negedge clk); chk1("t2_dbg_ack", dbg_ack_o, 1'b1); chk1("t2_core_ack_dbg", core_ack_o, 1'b0);
    tick(); dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    @(negedge clk); chk1("t2_rel_grant", dbg_grant_o, 1'b0);
    tick(); @(negedge clk); chk1("t2_core_hold", core_hold_o, 1'b0);
    tick();

    // Core and debug requests arrive in the same cycle, and debug then drops its request while in DRAIN.
    rsp_lat = 3; rsp_data = 32'hABAB_0001;
    core_req_i = 1'b1; core_addr_i = 32'h0000_6000;
    dbg_req_i = 1'b1; dbg_addr_i = 32'h0000_7000;
    @(negedge clk); chk32("t3_core_first", bus_addr_o, 32'h0000_6000);
    tick(); dbg_req_i = 1'b0;
    @(negedge clk); chk1("t3_drain_hold", core_hold_o, 1'b1);
    tick(); tick(); @(negedge clk);
    chk1("t3_core_ack", core_ack_o, 1'b1); chk32("t3_core_rdata", core_rdata_o, 32'hABAB_0001);
    chk1("t3_no_dbg_ack", dbg_ack_o, 1'b0);
    tick(); core_req_i = 1'b0;
    @(negedge clk); chk1("t3_grant", dbg_grant_o, 1'b1); chk1("t3_bus_req", bus_req_o, 1'b0);
    tick(); @(negedge clk); chk1("t3_rel_grant", dbg_grant_o, 1'b0); chk1("t3_rel_hold", core_hold_o, 1'b1);
    tick(); @(negedge clk); chk1("t3_core_hold", core_hold_o, 1'b0);
    tick();

    // Halt with three back-to-back debug writes. Hold stays high, then falls 2 cycles after halt drops.
    rsp_lat = 0; rsp_data = 32'h0;
    halt_req_i = 1'b1;
    tick();
    mon_hold = 1'b1;
    dbg_access(1'b1, 32'h0000_0100, 32'h0000_0001, rd, w); chk32("t4_wait0", 32'(w), 32'd1);
    dbg_access(1'b1, 32'h0000_0104, 32'h0000_0002, rd, w); chk32("t4_wait1", 32'(w), 32'd0);
    dbg_access(1'b1, 32'h0000_0108, 32'h0000_0003, rd, w); chk32("t4_wait2", 32'(w), 32'd0);
    halt_req_i = 1'b0;
    @(negedge clk); chk1("t4_hold_h0", core_hold_o, 1'b1);
    tick(); @(negedge clk); chk1("t4_hold_h1", core_hold_o, 1'b1);
    tick(); mon_hold = 1'b0;
    @(negedge clk); chk1("t4_hold_h2", core_hold_o, 1'b0);
    chk1("t4_hold_never_low", hold_low_seen, 1'b0);
    tick();

    // Reset is applied in DBG while a write is still waiting for its ack.
    rsp_lat = -1;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h0000_5000; dbg_wdata_i = 32'h0000_7777;
    tick(); tick(); @(negedge clk); chk1("t5_grant", dbg_grant_o, 1'b1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    @(negedge clk);
    chk1("t5_hold", core_hold_o, 1'b0); chk1("t5_grant_after", dbg_grant_o, 1'b0);
    chk1("t5_dbg_ack", dbg_ack_o, 1'b0);
    tick();

    // The bus never acks a debug read.
    rsp_lat = -1;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h0000_4000;
`ifdef DBG_ARB_TIMEOUT_EN
    got = 1'b0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dbg_ack_o) begin
        got = 1'b1;
        chk32("t6_to_rdata", dbg_rdata_o, 32'h0);
        chk1("t6_to_err", bus_err_o, 1'b1);
        break;
      end
      tick();
    end
    chk1("t6_to_ack_seen", got, 1'b1);
    chk32("t6_to_cycle", 32'(k), 32'd17);
    tick(); dbg_req_i = 1'b0;
    @(negedge clk); chk1("t6_err_pulse", bus_err_o, 1'b0); chk1("t6_rel_grant", dbg_grant_o, 1'b0);
    tick(); @(negedge clk); chk1("t6_core_hold", core_hold_o, 1'b0);
`else
    acks = 0; got = 1'b0;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (dbg_ack_o) acks++;
      if (bus_err_o) got = 1'b1;
      tick();
    end
    chk32("t6_no_ack", 32'(acks), 32'd0);
    chk1("t6_no_err", got, 1'b0);
    chk1("t6_still_granted", dbg_grant_o, 1'b1);
    dbg_req_i = 1'b0;
    tick(); tick();
    @(negedge clk); chk1("t6_core_hold", core_hold_o, 1'b0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbg_bus_arbiter.md
# dbg_bus_arbiter

Arbitrates the single system memory bus between the RISC-V core's load/store/fetch master and the JTAG debug module's memory port (`op_req`/`mem_*`). It also sequences core stall while the debug module halts the core or accesses memory. It sits between the core, the debug module and the bus interconnect. Ownership changes only at transaction boundaries: an in-flight core access always completes before the debug module takes the bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: cycles a granted request may wait for `bus_ack_i` before abort. Used only when the timeout feature is compiled in.
- `TO_W`, default 8: timeout counter width. Must satisfy 2^TO_W ≥ TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req_i`  in  1  core request; held high until `core_ack_o`.
- `core_we_i`  in  1  core write enable.
- `core_addr_i`  in  32  core address.
- `core_wdata_i`  in  32  core write data.
- `core_rdata_o`  out  32  core read data.
- `core_ack_o`  out  1  core access complete.
- `core_hold_o`  out  1  stall to core; the core must not raise a new `core_req_i` while this is high.
- `dbg_req_i`  in  1  debug module request (`op_req`); held until `dbg_ack_o`.
- `dbg_we_i`  in  1  debug write enable.
- `dbg_addr_i`  in  32  debug address.
- `dbg_wdata_i`  in  32  debug write data.
- `dbg_rdata_o`  out  32  debug read data.
- `dbg_ack_o`  out  1  debug access complete.
- `halt_req_i`  in  1  debug halt request (level).
- `bus_req_o`  out  1  request to interconnect.
- `bus_we_o`  out  1  write enable to interconnect.
- `bus_addr_o`  out  32  address to interconnect.
- `bus_wdata_o`  out  32  write data to interconnect.
- `bus_rdata_i`  in  32  read data from interconnect.
- `bus_ack_i`  in  1  completion from interconnect.
- `dbg_grant_o`  out  1  high while the debug module owns the bus.
- `bus_err_o`  out  1  one-cycle pulse on a timeout abort.

## Operation
State register has four states: CORE, DRAIN, DBG, RELEASE. Reset enters CORE.

Bus multiplexing (combinational from the state register):
- CORE and DRAIN: the core owns the bus. `bus_*` = `core_*`; `core_ack_o` = `bus_ack_i`; `core_rdata_o` = `bus_rdata_i`.
- DBG: the debug module owns the bus. `bus_*` = `dbg_*`; `dbg_ack_o` = `bus_ack_i`; `dbg_rdata_o` = `bus_rdata_i`.
- RELEASE: `bus_req_o` = 0.
- In every state, the non-owner's ack is 0 and its rdata is 0.

Control outputs:
- `core_hold_o` is 1 in DRAIN, DBG and RELEASE.
- `dbg_grant_o` is 1 only in DBG.

Transitions:
- CORE → DRAIN when (`dbg_req_i` | `halt_req_i`) = 1.
- DRAIN → DBG when `core_req_i` = 0, or when `bus_ack_i` = 1 this cycle (the core access completes in DRAIN).
- DBG → RELEASE when `dbg_req_i` = 0, `halt_req_i` = 0 and no debug access is pending.
- DBG → DBG while `halt_req_i` = 1, including between debug accesses. The core stays held.
- RELEASE → CORE unconditionally, after one turnaround cycle.

Boundary cases:
- Simultaneous `dbg_req_i` and core request in CORE: the core access is issued and completes first. Debug waits in DRAIN.
- `dbg_req_i` dropping while in DRAIN: proceed to DBG anyway, then RELEASE.
- `rst` mid-transaction: state returns to CORE, the counter is cleared, all acks are 0. The interconnect must also be reset.

## Timing
- Reset values: `core_hold_o`=0, `dbg_grant_o`=0, `bus_req_o`=`core_req_i` (CORE pass-through), all acks 0, all rdata 0, `bus_err_o`=0.
- Debug latency with the core idle: `dbg_req_i` rises in cycle N → DRAIN in N+1 → DBG in N+2, with `bus_req_o` sourced from debug in N+2.
- Return latency: the last `dbg_ack_o` in cycle M with requests low → RELEASE in M+1 → CORE in M+2.
- Acks and rdata are combinational pass-through, so there is zero added latency on the data path.

## Configuration
- `DBG_ARB_TIMEOUT_EN` defined:
  - A TO_W-bit counter increments while `bus_req_o`=1 and `bus_ack_i`=0, and clears on ack or owner change.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter drives the current owner's ack=1 with rdata=32'h0 and pulses `bus_err_o` for one cycle. `bus_ack_i` arriving in that same cycle is honoured normally with no error.
- Undefined: the arbiter waits indefinitely for `bus_ack_i`, `bus_err_o` is tied 0, and no counter is built.

## Test plan
- Idle core: `dbg_req_i`=1, `dbg_addr_i`=32'h1000_0000, read; the bus returns 32'hCAFE_F00D after 2 cycles → `dbg_grant_o` high 2 cycles after the request, `dbg_rdata_o`=32'hCAFE_F00D, RELEASE then CORE.
- Core access in flight (ack delayed 5 cycles) when `dbg_req_i` rises → `core_ack_o` delivered, DRAIN→DBG on the ack cycle, debug access issued the next cycle, core never sees `dbg` data.
- `halt_req_i`=1 with 3 back-to-back debug writes → `core_hold_o` stays 1 throughout; it drops 2 cycles after `halt_req_i` falls with no debug request pending.
- `rst` pulsed while in DBG with a write pending → next cycle state is CORE, `core_hold_o`=0, `dbg_ack_o`=0.
- With `DBG_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16: the bus never acks a debug read → `dbg_ack_o`=1 with rdata 0 and `bus_err_o` pulsed at cycle 16 of the request, then normal release. Without the macro: no ack after 1000 cycles.
